// File: rtl/divu_32_pkg.sv
// Shared ALU definitions for the iterative unsigned divider: width, FSM encoding
// and iteration counter sizing.
package divu_32_pkg;

    localparam int DIVU_WIDTH = 32;
    localparam int ITERS      = 32;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } divu_state_t;

endpackage

// File: rtl/sub_32.sv
// Library 32-bit subtractor: diff = a - b with carry-out (carry_out=1 means no borrow),
// the same borrow-based compare used for unsigned set-less-than.
module sub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        carry_out
);

    logic [32:0] sum;

    // a + ~b + 1 in 33 bits; the top bit is the carry, i.e. a >= b.
    assign sum       = {1'b0, a} + {1'b0, ~b} + 33'd1;
    assign diff      = sum[31:0];
    assign carry_out = sum[32];

endmodule

// File: rtl/divu_32.sv
// Iterative 32-bit unsigned divider: one restoring compare-subtract per clock,
// 32 steps per operation, start/busy/done handshake.
module divu_32
    import divu_32_pkg::*;
#(
    parameter int WIDTH = DIVU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    divu_state_t      state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] trial;
    logic             no_borrow;

    // The partial remainder is always below 2^31 before the final shift, so the
    // bit shifted out of R is never significant.
    assign shift_r = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    sub_32 u_trial_sub (
        .a         (shift_r),
        .b         (div_q),
        .diff      (trial),
        .carry_out (no_borrow)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    div_d = b;
                    cnt_d = '0;
                    if (b == '0) begin
                        state_d = ST_DONE;
                        q_d     = '1;
                        r_d     = a;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        q_d     = a;
                        r_d     = '0;
                        dz_d    = 1'b0;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (no_borrow) begin
                    r_d = trial;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shift_r;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_divu_32.sv
// Self-checking bench for divu_32: table of directed divisions plus hand-written
// sequences for ignored start, back-to-back operation and mid-run reset.
module tb_divu_32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    divu_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a_in),
        .b         (b_in),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for done; lat counts posedges from the accepting edge inclusive.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int lat;
        int bc;
        int exp_lat;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        wait_done(lat, bc);
        exp_lat = (b == 32'd0) ? 1 : 33;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_cycles", 32'(bc), (b == 32'd0) ? 32'd0 : 32'd32);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_zero", {31'd0, div_zero}, {31'd0, edz});
        $display("op a=%0h b=%0h -> q=%0h r=%0h dz=%0b lat=%0d busy=%0d",
                 a, b, quotient, remainder, div_zero, lat, bc);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("q_hold", quotient, eq);
    endtask

    initial begin
        int lat;
        int bc;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,   1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0};
        vecs[2] = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,   1'b0};
        vecs[3] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1};
        vecs[4] = '{32'd9,          32'd3,          32'd3,          32'd0,   1'b0};
        vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,   1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0};
        vecs[7] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,   1'b0};
        vecs[8] = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,   1'b0};
        vecs[9] = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

        // start pulsed during RUN must be ignored
        @(negedge clk);
        a_in = 32'd100; b_in = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        a_in = 32'd3; b_in = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        lat = lat + 10;
        chk("ign_latency", 32'(lat), 32'd33);
        chk("ign_quotient", quotient, 32'd14);
        chk("ign_remainder", remainder, 32'd2);
        $display("ignored-start op -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        @(negedge clk);

        // back-to-back with start held high
        a_in = 32'd50; b_in = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in = 32'd49; b_in = 32'd50;
        wait_done(lat, bc);
        chk("b2b1_latency", 32'(lat), 32'd33);
        chk("b2b1_quotient", quotient, 32'd10);
        chk("b2b1_remainder", remainder, 32'd0);
        $display("b2b op1 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, bc);
        chk("b2b2_gap", 32'(lat), 32'd33);
        chk("b2b2_quotient", quotient, 32'd0);
        chk("b2b2_remainder", remainder, 32'd49);
        $display("b2b op2 -> q=%0d r=%0d gap=%0d", quotient, remainder, lat);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_idle_done", {31'd0, done}, 32'd0);

        // asynchronous reset mid-RUN
        a_in = 32'd1000; b_in = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_quotient", quotient, 32'd0);
        chk("arst_remainder", remainder, 32'd0);
        chk("arst_flags", {29'd0, busy, done, div_zero}, 32'd0);
        $display("async reset mid-run -> q=%0h r=%0h busy=%0b", quotient, remainder, busy);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
